// File: rtl/bit_serial_adder_if.sv
// Request/result bundle for the bit-serial adder: operands and start in,
// busy/done status and registered sum out.
interface bit_serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] z;
   logic             cout;
   logic             ovf;

   modport master (
      output start, a, b, cin,
      input  busy, done, z, cout, ovf
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, z, cout, ovf
   );
endinterface

// File: rtl/bit_serial_adder.sv
// Multi-bit adder that reuses a single full-adder slice, one bit per cycle,
// LSB first, with the ripple carry held in a flip-flop between bits.
module bit_serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   bit_serial_adder_if.slave  bus
);
   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_nx;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;

   logic             load_c;
   logic             step_c;
   logic             finish_c;
   logic             sum_c;
   logic             co_c;

   // Full-adder slice fed from the operand LSBs and the carry flip-flop.
   assign sum_c = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
   assign co_c  = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (cnt_q == LAST) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load_c   = 1'b0;
      step_c   = 1'b0;
      finish_c = 1'b0;
      case (state_q)
         IDLE: load_c = bus.start;
         RUN: begin
            step_c   = 1'b1;
            finish_c = (cnt_q == LAST);
         end
         default: ;
      endcase
   end

   // Operand/result shift registers, carry, bit counter and output latches.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         bus.z    <= '0;
         bus.cout <= 1'b0;
         bus.ovf  <= 1'b0;
      end else if (load_c) begin
         a_sh_q  <= bus.a;
         b_sh_q  <= bus.b;
         carry_q <= bus.cin;
         cnt_q   <= '0;
      end else if (step_c) begin
         a_sh_q  <= a_sh_q >> 1;
         b_sh_q  <= b_sh_q >> 1;
         res_q   <= {sum_c, res_q[WIDTH-1:1]};
         carry_q <= co_c;
         cnt_q   <= cnt_q + CW'(1);
         if (finish_c) begin
            // carry_q is still the carry into the MSB on this edge.
            bus.z    <= {sum_c, res_q[WIDTH-1:1]};
            bus.cout <= co_c;
            bus.ovf  <= carry_q ^ co_c;
         end
      end
   end

   // Status flags registered from the next state so they align with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
      end else begin
         bus.busy <= (state_nx != IDLE);
         bus.done <= (state_nx == DONE);
      end
   end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed corner cases, random
// operands against an arithmetic model, and an exhaustive 2-bit sweep.
module tb_bit_serial_adder;
   logic clk;
   logic rst;
   int   nvec;
   int   nerr;

   bit_serial_adder_if #(.WIDTH(8)) bus8 ();
   bit_serial_adder_if #(.WIDTH(2)) bus2 ();

   bit_serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
   bit_serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Runs one 8-bit add; lat is the edge index (E0 = accept) where done was seen.
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                      output logic [7:0] oz, output logic oc, output logic oo,
                      output int lat, output int npulse);
      bus8.a = ta; bus8.b = tb_; bus8.cin = tc; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      lat = 0; npulse = 0; oz = '0; oc = 1'b0; oo = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1) begin
            npulse++;
            if (lat == 0) lat = k;
            oz = bus8.z; oc = bus8.cout; oo = bus8.ovf;
         end
      end
   endtask

   task automatic op2(input logic [1:0] ta, input logic [1:0] tb_, input logic tc,
                      output logic [1:0] oz, output logic oc, output logic oo,
                      output int lat, output int npulse);
      bus2.a = ta; bus2.b = tb_; bus2.cin = tc; bus2.start = 1'b1;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      lat = 0; npulse = 0; oz = '0; oc = 1'b0; oo = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (bus2.done === 1'b1) begin
            npulse++;
            if (lat == 0) lat = k;
            oz = bus2.z; oc = bus2.cout; oo = bus2.ovf;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      nvec++;
      if ({bus8.busy, bus8.done, bus8.z, bus8.cout, bus8.ovf} !== 11'd0) begin
         nerr++;
         $display("FAIL reset8: got %b expected all zero",
                  {bus8.busy, bus8.done, bus8.z, bus8.cout, bus8.ovf});
      end
      nvec++;
      if ({bus2.busy, bus2.done, bus2.z, bus2.cout, bus2.ovf} !== 5'd0) begin
         nerr++;
         $display("FAIL reset2: got %b expected all zero",
                  {bus2.busy, bus2.done, bus2.z, bus2.cout, bus2.ovf});
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Per-cycle busy/done profile for 0x0F + 0x01.
   task automatic test_timing();
      bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         @(posedge clk); #1;
         bus8.start = 1'b0;
         nvec++;
         if (bus8.busy !== (k <= 8) || bus8.done !== (k == 8)) begin
            nerr++;
            $display("FAIL timing E%0d: busy=%b done=%b expected busy=%b done=%b",
                     k, bus8.busy, bus8.done, (k <= 8), (k == 8));
         end
         if (k == 8) begin
            nvec++;
            if ({bus8.cout, bus8.z, bus8.ovf} !== {1'b0, 8'h10, 1'b0}) begin
               nerr++;
               $display("FAIL timing_result: cout/z/ovf=%b/%h/%b expected 0/10/0",
                        bus8.cout, bus8.z, bus8.ovf);
            end
         end
      end
   endtask

   task automatic test_corners();
      logic [7:0] ta [4] = '{8'hFF, 8'hFF, 8'h7F, 8'h80};
      logic [7:0] tb_ [4] = '{8'h01, 8'hFF, 8'h01, 8'h80};
      logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [9:0] exp [4] = '{{1'b1, 8'h00, 1'b0}, {1'b1, 8'hFF, 1'b0},
                              {1'b0, 8'h80, 1'b1}, {1'b1, 8'h00, 1'b1}};
      logic [7:0] oz; logic oc, oo; int lat, np;
      for (int i = 0; i < 4; i++) begin
         op8(ta[i], tb_[i], tc[i], oz, oc, oo, lat, np);
         nvec++;
         if ({oc, oz, oo} !== exp[i] || lat != 8 || np != 1) begin
            nerr++;
            $display("FAIL corner%0d: cout/z/ovf=%b lat=%0d pulses=%0d expected %b lat=8 pulses=1",
                     i, {oc, oz, oo}, lat, np, exp[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ra, rb, oz; logic rc, oc, oo; int lat, np;
      logic [8:0] full; logic eo;
      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         full = 9'(ra) + 9'(rb) + 9'(rc);
         eo = (ra[7] == rb[7]) && (full[7] != ra[7]);
         op8(ra, rb, rc, oz, oc, oo, lat, np);
         nvec++;
         if ({oc, oz} !== full || oo !== eo || lat != 8 || np != 1) begin
            nerr++;
            $display("FAIL random %h+%h+%b: got %h ovf=%b lat=%0d pulses=%0d expected %h ovf=%b",
                     ra, rb, rc, {oc, oz}, oo, lat, np, full, eo);
         end
      end
   endtask

   // Start pulse and operand churn during RUN must not disturb the add.
   task automatic test_busy_ignore();
      int np = 0;
      bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0; bus8.start = 1'b1;
      for (int k = 0; k <= 14; k++) begin
         @(posedge clk); #1;
         bus8.start = (k == 2);
         bus8.a = (k == 2) ? 8'hAA : 8'($urandom);
         bus8.b = (k == 2) ? 8'h55 : 8'($urandom);
         bus8.cin = 1'($urandom);
         if (bus8.done === 1'b1) np++;
      end
      nvec++;
      if (np != 1 || bus8.z !== 8'h02 || bus8.cout !== 1'b0) begin
         nerr++;
         $display("FAIL busy_ignore: pulses=%0d z=%h cout=%b expected pulses=1 z=02 cout=0",
                  np, bus8.z, bus8.cout);
      end
   endtask

   task automatic test_mid_reset();
      int np = 0;
      logic [7:0] oz; logic oc, oo; int lat;
      bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      nvec++;
      if ({bus8.busy, bus8.done, bus8.z, bus8.cout, bus8.ovf} !== 11'd0) begin
         nerr++;
         $display("FAIL mid_reset: busy/done/z/cout/ovf=%b expected all zero",
                  {bus8.busy, bus8.done, bus8.z, bus8.cout, bus8.ovf});
      end
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1) np++;
      end
      nvec++;
      if (np != 0) begin
         nerr++;
         $display("FAIL mid_reset_nodone: pulses=%0d expected 0", np);
      end
      op8(8'h03, 8'h04, 1'b0, oz, oc, oo, lat, np);
      nvec++;
      if (oz !== 8'h07 || oc !== 1'b0 || lat != 8 || np != 1) begin
         nerr++;
         $display("FAIL after_reset: z=%h cout=%b lat=%0d pulses=%0d expected z=07 cout=0 lat=8 pulses=1",
                  oz, oc, lat, np);
      end
   endtask

   // Start held high: accepts every WIDTH+2 cycles.
   task automatic test_back_to_back();
      int pulses[$];
      logic [7:0] ra, rb; logic [8:0] full;
      ra = 8'($urandom); rb = 8'($urandom);
      full = 9'(ra) + 9'(rb) + 9'd1;
      bus8.a = ra; bus8.b = rb; bus8.cin = 1'b1; bus8.start = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1) begin
            pulses.push_back(k);
            nvec++;
            if ({bus8.cout, bus8.z} !== full) begin
               nerr++;
               $display("FAIL b2b_result: got %h expected %h", {bus8.cout, bus8.z}, full);
            end
         end
      end
      bus8.start = 1'b0;
      nvec++;
      if (pulses.size() != 3 || pulses[0] != 8 || pulses[1] != 18 || pulses[2] != 28) begin
         nerr++;
         $display("FAIL b2b_spacing: %0d pulses first at %0d expected 3 pulses at 8,18,28",
                  pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic test_exhaustive2();
      logic [1:0] oz; logic oc, oo; int lat, np;
      logic [2:0] full; logic eo;
      for (int ia = 0; ia < 4; ia++)
         for (int ib = 0; ib < 4; ib++)
            for (int ic = 0; ic < 2; ic++) begin
               full = 3'(ia + ib + ic);
               eo = (2'(ia) >> 1 == 2'(ib) >> 1) && (full[1] != 1'(ia >> 1));
               op2(2'(ia), 2'(ib), 1'(ic), oz, oc, oo, lat, np);
               nvec++;
               if ({oc, oz} !== full || oo !== eo || lat != 2 || np != 1) begin
                  nerr++;
                  $display("FAIL w2 %0d+%0d+%0d: got %b ovf=%b lat=%0d pulses=%0d expected %b ovf=%b",
                           ia, ib, ic, {oc, oz}, oo, lat, np, full, eo);
               end
            end
   endtask

   initial begin
      nvec = 0; nerr = 0;
      rst = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
      #2;
      test_reset();
      test_timing();
      test_corners();
      test_random();
      test_busy_ignore();
      test_mid_reset();
      test_back_to_back();
      test_exhaustive2();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
